spin_sequencer: RTL and testbench



---
 rtl/slot_pkg.sv | 40 ++++
 rtl/reel_scroller.sv | 62 ++++++
 rtl/spin_sequencer.sv | 179 +++++++++++++++++
 tb/tb_spin_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/slot_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package  : slot_pkg
// Summary  : Reel-strip constants, sprite index and sequencer state types.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package slot_pkg;

  localparam int N_SPRITES = 7;
  localparam int SPRITE_H  = 64;

  typedef logic [2:0] sprite_idx_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SPINNING   = 3'd1,
    REEL1_STOP = 3'd2,
    REEL2_STOP = 3'd3,
    REEL3_STOP = 3'd4
  } spin_state_t;

  // Reel being brought to rest in a stop state (0-based).
  function automatic logic [1:0] stop_reel(input spin_state_t s);
    case (s)
      REEL1_STOP: stop_reel = 2'd0;
      REEL2_STOP: stop_reel = 2'd1;
      default:    stop_reel = 2'd2;
    endcase
  endfunction

  function automatic spin_state_t next_stop_state(input spin_state_t s);
    case (s)
      REEL1_STOP: next_stop_state = REEL2_STOP;
      REEL2_STOP: next_stop_state = REEL3_STOP;
      default:    next_stop_state = IDLE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/reel_scroller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : reel_scroller
// Summary  : One reel's wrapping scroll offset and its frozen flag.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module reel_scroller #(
  parameter int STRIP = 448,
  parameter int SPEED = 8,
  parameter int OFF_W = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             advance,
  input  logic             freeze,
  input  logic [OFF_W-1:0] target,
  input  logic             clear_stopped,
  output logic [OFF_W-1:0] offset,
  output logic             at_target,
  output logic             stopped
);

  logic [OFF_W-1:0] offset_q, offset_d;
  logic             stopped_q, stopped_d;
  logic [OFF_W:0]   w_sum;

  assign w_sum = {1'b0, offset_q} + (OFF_W+1)'(SPEED);

  always_comb begin
    offset_d  = offset_q;
    stopped_d = stopped_q;
    if (clear_stopped) begin
      stopped_d = 1'b0;
    end
    if (freeze) begin
      stopped_d = 1'b1;
    end else if (advance && !stopped_q) begin
      // Offsets stay multiples of SPEED, so a single subtract wraps the strip.
      if (w_sum >= (OFF_W+1)'(STRIP)) begin
        offset_d = OFF_W'(w_sum - (OFF_W+1)'(STRIP));
      end else begin
        offset_d = w_sum[OFF_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      offset_q  <= '0;
      stopped_q <= 1'b0;
    end else begin
      offset_q  <= offset_d;
      stopped_q <= stopped_d;
    end
  end

  assign offset    = offset_q;
  assign at_target = (offset_q == target);
  assign stopped   = stopped_q;

endmodule
`default_nettype wire

// File: rtl/spin_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : spin_sequencer
// Summary  : Frame-locked spin/stop scheduler landing three reels on targets.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module spin_sequencer #(
  parameter int N_SPRITES       = slot_pkg::N_SPRITES,
  parameter int SPRITE_H        = slot_pkg::SPRITE_H,
  parameter int SPEED           = 8,
  parameter int SPIN_FRAMES     = 60,
  parameter int STOP_GAP_FRAMES = 30,
  parameter int OFF_W           = $clog2(N_SPRITES * SPRITE_H)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 vsync,
  input  logic                 spin_req,
  input  slot_pkg::sprite_idx_t final1_sprite,
  input  slot_pkg::sprite_idx_t final2_sprite,
  input  slot_pkg::sprite_idx_t final3_sprite,
  output logic                 spin_ack,
  output logic                 busy,
  output logic                 start_spin,
  output logic [OFF_W-1:0]     reel_offset1,
  output logic [OFF_W-1:0]     reel_offset2,
  output logic [OFF_W-1:0]     reel_offset3,
  output logic [2:0]           reel_stopped,
  output logic                 done,
  output logic                 sprite_err
);

  import slot_pkg::spin_state_t, slot_pkg::sprite_idx_t;
  import slot_pkg::IDLE, slot_pkg::SPINNING, slot_pkg::REEL3_STOP;
  import slot_pkg::REEL1_STOP, slot_pkg::REEL2_STOP;
  import slot_pkg::stop_reel, slot_pkg::next_stop_state;

  localparam int          STRIP     = N_SPRITES * SPRITE_H;
  localparam logic [7:0]  SPIN_LAST = 8'(SPIN_FRAMES);
  localparam logic [7:0]  GAP_MIN   = 8'(STOP_GAP_FRAMES);
  localparam sprite_idx_t MAX_IDX   = sprite_idx_t'(N_SPRITES - 1);

  spin_state_t      state_q, state_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             vsync_q;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [OFF_W-1:0] tgt_q [3];
  logic [OFF_W-1:0] tgt_d [3];

  logic             w_tick;
  logic [1:0]       w_k;
  logic [2:0]       w_advance, w_freeze, w_at_tgt, w_stopped;
  logic             w_clear_stopped;
  sprite_idx_t      w_final [3];
  logic [OFF_W-1:0] w_off [3];

  assign w_tick     = vsync_q & ~vsync;
  assign w_k        = stop_reel(state_q);
  assign w_final[0] = final1_sprite;
  assign w_final[1] = final2_sprite;
  assign w_final[2] = final3_sprite;

  always_comb begin
    state_d         = state_q;
    frame_cnt_d     = frame_cnt_q;
    ack_d           = 1'b0;
    done_d          = 1'b0;
    err_d           = err_q;
    tgt_d           = tgt_q;
    w_advance       = 3'b000;
    w_freeze        = 3'b000;
    w_clear_stopped = 1'b0;
    case (state_q)
      IDLE: begin
        if (spin_req) begin
          ack_d           = 1'b1;
          state_d         = SPINNING;
          frame_cnt_d     = '0;
          w_clear_stopped = 1'b1;
          err_d           = 1'b0;
          for (int k = 0; k < 3; k++) begin
            if (w_final[k] > MAX_IDX) begin
              tgt_d[k] = '0;
              err_d    = 1'b1;
            end else begin
              tgt_d[k] = OFF_W'(int'(w_final[k]) * SPRITE_H);
            end
          end
        end
      end
      SPINNING: begin
        if (w_tick) begin
          w_advance = 3'b111;
          if (frame_cnt_q + 8'd1 == SPIN_LAST) begin
            state_d     = REEL1_STOP;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
      REEL1_STOP, REEL2_STOP, REEL3_STOP: begin
        if (w_tick) begin
          // Target is checked before advancing, so the landing reel never overshoots.
          if (frame_cnt_q >= GAP_MIN && w_at_tgt[w_k]) begin
            w_freeze[w_k] = 1'b1;
            frame_cnt_d   = '0;
            state_d       = next_stop_state(state_q);
            done_d        = (state_q == REEL3_STOP);
          end else begin
            w_advance = ~w_stopped;
            if (frame_cnt_q != 8'hFF) begin
              frame_cnt_d = frame_cnt_q + 8'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      vsync_q     <= 1'b1;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        tgt_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      vsync_q     <= vsync;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      tgt_q       <= tgt_d;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_reel
    reel_scroller #(
      .STRIP (STRIP),
      .SPEED (SPEED),
      .OFF_W (OFF_W)
    ) u_reel (
      .clk           (clk),
      .reset_n       (reset_n),
      .advance       (w_advance[g]),
      .freeze        (w_freeze[g]),
      .target        (tgt_q[g]),
      .clear_stopped (w_clear_stopped),
      .offset        (w_off[g]),
      .at_target     (w_at_tgt[g]),
      .stopped       (w_stopped[g])
    );
  end

  assign spin_ack     = ack_q;
  assign start_spin   = ack_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sprite_err   = err_q;
  assign reel_stopped = w_stopped;
  assign reel_offset1 = w_off[0];
  assign reel_offset2 = w_off[1];
  assign reel_offset3 = w_off[2];

endmodule
`default_nettype wire

// File: tb/tb_spin_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_spin_sequencer
// Summary  : Directed and randomized spins checked against an arithmetic model.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_spin_sequencer;

  localparam int NS    = 7;
  localparam int SH    = 16;
  localparam int SP    = 8;
  localparam int SF    = 4;
  localparam int GAP   = 2;
  localparam int STRIP = NS * SH;
  localparam int OW    = $clog2(STRIP);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          vsync = 1'b1;
  logic          spin_req = 1'b0;
  logic [2:0]    f1 = '0, f2 = '0, f3 = '0;
  logic          spin_ack, busy, start_spin, done, sprite_err;
  logic [OW-1:0] o1, o2, o3;
  logic [2:0]    reel_stopped;

  int checks = 0;
  int failures = 0;
  int n_ack = 0, n_done = 0;
  int exp_ack = 0, exp_done = 0;
  int m_off [3];

  spin_sequencer #(
    .N_SPRITES       (NS),
    .SPRITE_H        (SH),
    .SPEED           (SP),
    .SPIN_FRAMES     (SF),
    .STOP_GAP_FRAMES (GAP)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .vsync         (vsync),
    .spin_req      (spin_req),
    .final1_sprite (f1),
    .final2_sprite (f2),
    .final3_sprite (f3),
    .spin_ack      (spin_ack),
    .busy          (busy),
    .start_spin    (start_spin),
    .reel_offset1  (o1),
    .reel_offset2  (o2),
    .reel_offset3  (o3),
    .reel_stopped  (reel_stopped),
    .done          (done),
    .sprite_err    (sprite_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (spin_ack) n_ack <= n_ack + 1;
    if (done)     n_done <= n_done + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_offs(input string tag);
    chk({tag, ".off1"}, 32'(o1), m_off[0]);
    chk({tag, ".off2"}, 32'(o2), m_off[1]);
    chk({tag, ".off3"}, 32'(o3), m_off[2]);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".ack"}, 32'(spin_ack), 0);
    chk({tag, ".start"}, 32'(start_spin), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".err"}, 32'(sprite_err), 0);
    chk({tag, ".stopped"}, 32'(reel_stopped), 0);
    chk({tag, ".o1"}, 32'(o1), 0);
    chk({tag, ".o2"}, 32'(o2), 0);
    chk({tag, ".o3"}, 32'(o3), 0);
  endtask

  // Ticks a reel needs in its stop state: first tick index >= GAP at which
  // it already sits on its target; that tick itself is the freeze tick.
  function automatic int land(input int o, input int t);
    int r = -1;
    for (int j = GAP + STRIP / SP - 1; j >= GAP; j--) begin
      if ((o + j * SP) % STRIP == t) r = j;
    end
    return r;
  endfunction

  task automatic tick(input bit toggle);
    @(negedge clk);
    vsync = 1'b0;
    if (toggle) spin_req = 1'($urandom % 2);
    @(negedge clk);
    vsync = 1'b1;
    if (toggle) spin_req = 1'($urandom % 2);
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  task automatic run_spin(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                          input bit toggle, input bit req_at_done, input bit rst_mid);
    logic [2:0] fin [3];
    int         tgt [3];
    bit         exp_err;
    int         j;
    logic [2:0] exp_stop;
    fin[0] = a; fin[1] = b; fin[2] = c;
    exp_err = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (fin[k] > 3'd6) begin
        tgt[k] = 0;
        exp_err = 1'b1;
      end else begin
        tgt[k] = int'(fin[k]) * SH;
      end
    end
    @(negedge clk);
    f1 = a; f2 = b; f3 = c;
    spin_req = 1'b1;
    @(negedge clk);
    exp_ack++;
    chk("accept.ack", 32'(spin_ack), 1);
    chk("accept.start", 32'(start_spin), 1);
    chk("accept.busy", 32'(busy), 1);
    chk("accept.err", 32'(sprite_err), 32'(exp_err));
    chk("accept.stopped", 32'(reel_stopped), 0);
    spin_req = 1'b0;
    f1 = 3'($urandom); f2 = 3'($urandom); f3 = 3'($urandom);
    @(negedge clk);
    chk("accept.ack_pulse", 32'(spin_ack), 0);

    for (int i = 0; i < SF; i++) begin
      tick(toggle);
      for (int r = 0; r < 3; r++) m_off[r] = (m_off[r] + SP) % STRIP;
    end
    chk_offs("spin");
    chk("spin.stopped", 32'(reel_stopped), 0);
    chk("spin.busy", 32'(busy), 1);

    exp_stop = 3'b000;
    for (int k = 0; k < 3; k++) begin
      j = land(m_off[k], tgt[k]);
      for (int i = 0; i < j; i++) begin
        if (rst_mid && k == 1 && i == 1) begin
          @(negedge clk);
          reset_n = 1'b0;
          spin_req = 1'b0;
          @(negedge clk);
          chk_idle("mid_reset");
          reset_n = 1'b1;
          m_off[0] = 0; m_off[1] = 0; m_off[2] = 0;
          return;
        end
        tick(toggle);
        for (int r = k; r < 3; r++) m_off[r] = (m_off[r] + SP) % STRIP;
      end
      chk("pre_freeze.stopped", 32'(reel_stopped), 32'(exp_stop));
      chk_offs("pre_freeze");
      @(negedge clk);
      vsync = 1'b0;
      if (k == 2) spin_req = req_at_done;
      @(negedge clk);
      if (k == 2) spin_req = 1'b0;
      exp_stop[k] = 1'b1;
      chk("freeze.stopped", 32'(reel_stopped), 32'(exp_stop));
      chk_offs("freeze");
      chk("freeze.on_target", (k == 0) ? 32'(o1) : (k == 1) ? 32'(o2) : 32'(o3), tgt[k]);
      chk("freeze.done", 32'(done), (k == 2) ? 1 : 0);
      chk("freeze.busy", 32'(busy), (k == 2) ? 0 : 1);
      vsync = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_freeze.done", 32'(done), 0);
    end
    exp_done++;
    spin_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("after.ack", 32'(spin_ack), 0);
    chk("after.busy", 32'(busy), 0);
    chk("after.ack_count", n_ack, exp_ack);
    chk("after.done_count", n_done, exp_done);
  endtask

  initial begin
    m_off[0] = 0; m_off[1] = 0; m_off[2] = 0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    chk_idle("reset");

    run_spin(3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0);
    chk("land123.o1", 32'(o1), 16);
    chk("land123.o2", 32'(o2), 32);
    chk("land123.o3", 32'(o3), 48);
    chk("land123.stopped", 32'(reel_stopped), 3'b111);

    // Reel 1 starts its stop at 48 and must pass 104 -> 0 before landing.
    run_spin(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("wrap.o1", 32'(o1), 0);

    run_spin(3'd3, 3'd1, 3'd4, 1'b1, 1'b1, 1'b0);

    run_spin(3'd5, 3'd7, 3'd2, 1'b0, 1'b0, 1'b0);
    chk("bad_idx.err", 32'(sprite_err), 1);
    chk("bad_idx.o2", 32'(o2), 0);
    run_spin(3'd2, 3'd2, 3'd2, 1'b0, 1'b0, 1'b0);
    chk("err_cleared", 32'(sprite_err), 0);

    run_spin(3'd4, 3'd5, 3'd6, 1'b0, 1'b0, 1'b1);
    run_spin(3'd6, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 6; n++) begin
      run_spin(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               1'($urandom % 2), 1'($urandom % 2), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
